// File: rtl/dsram_lsu.sv
// Load/store unit turning byte-addressed core requests into word-addressed SRAM reads/writes (RMW for sub-word stores).
// Latency accept->rsp_valid: 1 cycle on error, 2 for loads and word stores, 3 for sub-word stores.
// One transaction in flight: req_ready is low until the response handshakes; rsp_* held stable while rsp_ready is low.
module dsram_lsu #(
  parameter int m = 10,
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [31:0]  req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic [n-1:0] mem_addr,
  output logic         mem_w_en,
  output logic [n-1:0] mem_din,
  input  logic [n-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state_q;
  state_t state_d;

  // Registered copy of the accepted request; only what later cycles need.
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;

  logic        acc;
  logic        req_err_c;
  logic        range_err;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [n-1:0] load_ext;
  logic [n-1:0] merged;

  // Reset is folded in so the core never sees ready while the unit is held in reset.
  assign req_ready = (state_q == IDLE) && !rst;
  assign acc       = req_valid && req_ready;

  // Any address bit above the SRAM's byte range makes the request out of range.
  assign range_err = (req_addr >> (m + 2)) != 32'd0;

  // Request error: bad size, misaligned half/word, or out-of-range address.
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      SZ_BYTE: req_err_c = 1'b0;
      SZ_HALF: req_err_c = req_addr[0];
      SZ_WORD: req_err_c = |req_addr[1:0];
      default: req_err_c = 1'b1;
    endcase
    if (range_err) begin
      req_err_c = 1'b1;
    end
  end

  // Little-endian lane select from the word currently presented by the SRAM.
  assign byte_lane = mem_dout[{r_off, 3'b000} +: 8];
  assign half_lane = mem_dout[{r_off[1], 4'b0000} +: 16];

  // Load result: selected lane, sign- or zero-extended to the full data width.
  always_comb begin
    load_ext = mem_dout;
    case (r_size)
      SZ_BYTE: load_ext = {{(n-8){~r_uns & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_ext = {{(n-16){~r_uns & half_lane[15]}}, half_lane};
      default: load_ext = mem_dout;
    endcase
  end

  // Read-modify-write merge: old word with only the target lane(s) replaced.
  always_comb begin
    merged = mem_dout;
    if (r_size == SZ_BYTE) begin
      merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      merged[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: errors skip the SRAM, word stores skip the read, everything else reads first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (req_err_c) begin
            state_d = RSP;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (r_we) begin
          state_d = WR;
        end else begin
          state_d = RSP;
        end
      end
      WR: begin
        state_d = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture and SRAM-side outputs; strobes are decoded from the next state so they are flop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_uns    <= 1'b0;
      r_off    <= 2'b00;
      r_wdata  <= 16'd0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_w_en <= 1'b0;
    end else begin
      mem_w_en <= (state_d == WR);
      if (acc) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_off   <= req_addr[1:0];
        r_wdata <= req_wdata[15:0];
        // Failed requests leave the SRAM address untouched.
        if (!req_err_c) begin
          mem_addr <= {{(n-m){1'b0}}, req_addr[m+1:2]};
          if (req_we && (req_size == SZ_WORD)) begin
            mem_din <= req_wdata;
          end
        end
      end
      if ((state_q == RD) && r_we) begin
        mem_din <= merged;
      end
    end
  end

  // Response registers: loaded on entry to RSP, held until the handshake, then cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (state_d == RSP);
      case (state_q)
        IDLE: begin
          if (acc && req_err_c) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        RD: begin
          if (!r_we) begin
            rsp_rdata <= load_ext;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_lsu.sv
// Directed bench for dsram_lsu with a behavioural SRAM (combinational read, clocked write).
// Checks latency, data, error flag, write strobes, backpressure hold and mid-transaction reset.
// Responses are taken immediately except in the explicit stall sequence.
module tb_dsram_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_w_en;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:1023];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          wen_cnt  = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  dsram_lsu #(.m(10), .n(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_w_en     (mem_w_en),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[9:0]];

  // SRAM write port plus strobe bookkeeping.
  always @(posedge clk) begin
    if (mem_w_en) begin
      mem[mem_addr[9:0]] = mem_din;
      wen_cnt      = wen_cnt + 1;
      last_wr_addr = mem_addr;
      last_wr_data = mem_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request with rsp_ready high; checks latency, response and write activity.
  task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                     input logic [31:0] exp_waddr, input logic [31:0] exp_wdat);
    int cyc;
    int wen0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    wen0 = wen_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_data"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    chk({tag, "_ahi"}, {10'd0, mem_addr[31:10]}, 32'd0);
    if (we && !exp_e) begin
      chk({tag, "_wen"}, 32'(wen_cnt - wen0), 32'd1);
      chk({tag, "_waddr"}, last_wr_addr, exp_waddr);
      chk({tag, "_wdat"}, last_wr_data, exp_wdat);
    end else begin
      chk({tag, "_wen"}, 32'(wen_cnt - wen0), 32'd0);
    end
    @(posedge clk);
  endtask

  initial begin
    int wen0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_wen", 32'(mem_w_en), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_din", mem_din, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_rdy", 32'(req_ready), 32'd1);

    // Word store then word load.
    txn("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'd4, 32'hDEADBEEF);
    txn("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 32'd0, 32'd0);
    // Byte store merges into lane 1; upper wdata bits must be ignored.
    txn("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680, 32'h0, 1'b0, 3, 32'd4, 32'hDEAD80EF);
    txn("lb11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0, 2, 32'd0, 32'd0);
    txn("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 2, 32'd0, 32'd0);
    txn("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 32'd0, 32'd0);
    txn("lbu10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h000000EF, 1'b0, 2, 32'd0, 32'd0);
    // Half store into upper half.
    txn("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, 32'h0, 1'b0, 3, 32'd4, 32'h123480EF);
    // Error cases: no SRAM write, one-cycle latency, zero data.
    txn("eh13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 32'd0, 32'd0);
    txn("ew12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 32'd0, 32'd0);
    txn("eb1000", 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 32'd0, 32'd0);
    txn("esz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 32'd0, 32'd0);
    txn("esw12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 32'd0, 32'd0);
    txn("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h123480EF, 1'b0, 2, 32'd0, 32'd0);
    // Highest in-range byte is not an error.
    txn("sbfff", 1'b1, 2'b00, 1'b0, 32'hFFF, 32'h000000A5, 32'h0, 1'b0, 3, 32'd1023, 32'hA5000000);
    txn("lbfff", 1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 32'd0, 32'd0);

    // Backpressure: response held for 5 cycles with another request waiting.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_size = 2'b00; req_unsigned = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_v", 32'(rsp_valid), 32'd1);
      chk("stall_d", rsp_rdata, 32'h123480EF);
      chk("stall_rdy", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hs_v", 32'(rsp_valid), 32'd0);
    chk("hs_rdy", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("nx_v1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("nx_v2", 32'(rsp_valid), 32'd1);
    chk("nx_d", rsp_rdata, 32'h000000EF);
    @(posedge clk);

    // Reset during the WR cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h55; rsp_ready = 1'b1;
    wen0 = wen_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wen_hi", 32'(mem_w_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_wen_lo", 32'(mem_w_en), 32'd0);
    chk("mid_rspv", 32'(rsp_valid), 32'd0);
    chk("mid_rdy", 32'(req_ready), 32'd0);
    chk("mid_addr", mem_addr, 32'd0);
    chk("mid_din", mem_din, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rel_rdy", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_norsp", 32'(rsp_valid), 32'd0);
    end
    chk("mid_nowr", 32'(wen_cnt - wen0), 32'd0);
    txn("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 2, 32'd0, 32'd0);
    txn("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h123480EF, 1'b0, 2, 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
